// File: rtl/alu_sequencer.sv
// Operand/opcode sequencer for an external combinational ALU: synchronized,
// edge-detected buttons load A, B and the opcode, then one EXEC cycle captures the result.
module alu_sequencer #(
  parameter int N         = 8,
  parameter int N_op      = 6,
  parameter int N_buttons = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic signed [N-1:0]  i_switches,
  input  logic [N_buttons-1:0] i_buttons,
  input  logic signed [N-1:0]  i_alu_result,
  output logic signed [N-1:0]  o_alu_a,
  output logic signed [N-1:0]  o_alu_b,
  output logic [N_op-1:0]      o_alu_op,
  output logic signed [N-1:0]  o_leds,
  output logic [2:0]           o_state,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [N_buttons-1:0] sync1_q, sync2_q, prev_q;
  logic [N_buttons-1:0] btn_edge;
  logic signed [N-1:0]  a_q, a_d, b_q, b_d, leds_q, leds_d;
  logic [N_op-1:0]      op_q, op_d;
  logic                 done_q, done_d;
  logic                 ld_a, ld_b, ld_op;

  // Edge is combinational from the second sync flop, so the load lands two edges after capture.
  assign btn_edge = sync2_q & ~prev_q;
  assign ld_a     = btn_edge[0];
  assign ld_b     = btn_edge[1];
  assign ld_op    = btn_edge[2];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      leds_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      sync1_q <= i_buttons;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      leds_q  <= leds_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    leds_d  = leds_q;
    done_d  = (state_q == EXEC);
    case (state_q)
      WAIT_A: begin
        if (ld_a) begin
          a_d     = i_switches;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (ld_b) begin
          b_d     = i_switches;
          state_d = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (ld_op) begin
          op_d    = i_switches[N_op-1:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        leds_d  = i_alu_result;
        state_d = DONE;
      end
      DONE: begin
        // LOAD_A restarts, LOAD_B chains the previous result into A, LOAD_OP re-runs.
        if (ld_a) begin
          a_d     = i_switches;
          state_d = WAIT_B;
        end else if (ld_b) begin
          a_d     = leds_q;
          b_d     = i_switches;
          state_d = WAIT_OP;
        end else if (ld_op) begin
          op_d    = i_switches[N_op-1:0];
          state_d = EXEC;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign o_alu_a  = a_q;
  assign o_alu_b  = b_q;
  assign o_alu_op = op_q;
  assign o_leds   = leds_q;
  assign o_state  = state_q;
  assign o_done   = done_q;

endmodule
